// File: rtl/divider_mersenne_seq.sv
// divider_mersenne_seq: sequential quotient/remainder by a Mersenne divisor D = 2^K-1.
// One fold iteration runs per clock, with valid/ready handshakes on both sides.
// Optional feature macro: DIV_EARLY_EXIT_EN. When it is defined, the fold loop
// stops as soon as the quotient estimate stops changing.
//
// Identity used: x = q*D + r  <=>  x + q = q*2^K + r.
// Starting from q0 = (x+1)>>K, the recurrence q <= (q + x + 1)>>K converges
// monotonically to floor(x/D) within ceil(W/K) estimates. The remainder then
// falls out as the low K bits of x + q.
module divider_mersenne_seq #(
  parameter int W = 32,
  parameter int K = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-K:0]   out_q,
  output logic [K-1:0]   out_r
);

  localparam int ITERS = (W + K - 1) / K;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int QW    = W - K + 1;
  localparam logic [K-1:0] D = {K{1'b1}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ITER   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  x;
  logic [W:0]    v1;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;

  logic [W:0]    v1_in;
  logic [QW-1:0] q0;
  logic [W+1:0]  sum;
  logic [QW-1:0] q_next;
  logic [K-1:0]  r_next;
  logic          last_iter;

  // Fold datapath: the first estimate for a new dividend, the next estimate
  // from the current one, the remainder from the final estimate, and the
  // end-of-loop decision.
  always_comb begin
    v1_in     = {1'b0, in_x} + {{W{1'b0}}, 1'b1};
    q0        = QW'(v1_in >> K);
    sum       = {1'b0, v1} + {{(K+1){1'b0}}, q};
    q_next    = QW'(sum >> K);
    r_next    = K'({1'b0, x} + {{K{1'b0}}, q}) & D;
    last_iter = (cnt == CW'(1));
`ifdef DIV_EARLY_EXIT_EN
    if (q_next == q) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Control FSM plus registers for the iteration state and the results.
  // cnt holds the number of fold edges still to run. The edge that consumes
  // the last one moves the FSM to RESULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      x         <= '0;
      v1        <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            x        <= in_x;
            v1       <= v1_in;
            q        <= q0;
            cnt      <= CW'(ITERS - 1);
            in_ready <= 1'b0;
            state    <= (ITERS == 1) ? RESULT : ITER;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ITER: begin
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            state <= RESULT;
          end
        end
        RESULT: begin
          out_q     <= q;
          out_r     <= r_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_mersenne_seq.sv
// tb_divider_mersenne_seq: self-checking bench for divider_mersenne_seq.
// Instance a uses the default parameters (W=32, K=13). Instance b uses W=16, K=4.
// Latency is counted in edges, with the accept edge counted as edge 1, up to
// and including the edge that raises out_valid.
module tb_divider_mersenne_seq;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_x_a;
  logic [19:0] out_q_a;
  logic [12:0] out_r_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [15:0] in_x_b;
  logic [12:0] out_q_b;
  logic [3:0]  out_r_b;

  typedef struct {
    int          sel;
    logic [31:0] x;
    int unsigned q;
    int unsigned r;
    int          lat;
  } vec_t;

  typedef struct {
    int unsigned q;
    int unsigned r;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks;
  int   n_fail;

  divider_mersenne_seq #(.W(32), .K(13)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_x(in_x_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_q(out_q_a), .out_r(out_r_a)
  );

  divider_mersenne_seq #(.W(16), .K(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_q(out_q_b), .out_r(out_r_b)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready_a : in_ready_b;
  endfunction

  function automatic logic ov(input int sel);
    return (sel == 0) ? out_valid_a : out_valid_b;
  endfunction

  function automatic longint unsigned oq(input int sel);
    return (sel == 0) ? longint'(out_q_a) : longint'(out_q_b);
  endfunction

  function automatic longint unsigned orr(input int sel);
    return (sel == 0) ? longint'(out_r_a) : longint'(out_r_b);
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Wait for in_ready, present one dividend, push the expected result, and
  // return 1 time unit after the accept edge.
  task automatic apply_stimulus(input int sel, input logic [31:0] x,
                                input int unsigned eq, input int unsigned er);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!rdy(sel) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy(sel)) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    if (sel == 0) begin
      in_x_a     = x;
      in_valid_a = 1'b1;
    end else begin
      in_x_b     = x[15:0];
      in_valid_b = 1'b1;
    end
    e.q = eq;
    e.r = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  // Count edges until out_valid, then compare against the scoreboard.
  // A lat value of 0 skips the latency comparison.
  task automatic check_output(input int sel, input int lat);
    int   n;
    exp_t e;
    n = 1;
    while (!ov(sel) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ov(sel)) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    if (lat != 0) chk("latency", n, lat);
    chk("in_ready_low_while_out_valid", rdy(sel), 0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("quotient", oq(sel), e.q);
      chk("remainder", orr(sel), e.r);
    end
  endtask

  initial begin
    logic [31:0] rx;
    vec_t        v;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid_a  = 1'b0;
    in_valid_b  = 1'b0;
    in_x_a      = '0;
    in_x_b      = '0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;

    tbl.push_back('{0, 32'd8191,       1,      0,    EE ? 3 : 4});
    tbl.push_back('{0, 32'd8190,       0,      8190, EE ? 3 : 4});
    tbl.push_back('{0, 32'd0,          0,      0,    EE ? 3 : 4});
    tbl.push_back('{0, 32'hFFFF_FFFF,  524352, 63,   4});
    tbl.push_back('{0, 32'd16382,      2,      0,    4});
    tbl.push_back('{1, 32'd1000,       66,     10,   EE ? 4 : 5});
    tbl.push_back('{1, 32'd15,         1,      0,    EE ? 3 : 5});
    tbl.push_back('{1, 32'd65535,      4369,   0,    5});
    for (int i = 0; i < 4; i++) begin
      rx = $urandom;
      tbl.push_back('{0, rx, rx / 8191, rx % 8191, EE ? 0 : 4});
    end
    for (int i = 0; i < 2; i++) begin
      rx = {16'd0, 16'($urandom)};
      tbl.push_back('{1, rx, rx / 15, rx % 15, EE ? 0 : 5});
    end

    // Reset state, then in_ready on the first edge after release.
    #12;
    chk("reset_in_ready", in_ready_a, 0);
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_out_q", out_q_a, 0);
    chk("reset_out_r", out_r_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", in_ready_a, 1);
    chk("in_ready_after_reset_b", in_ready_b, 1);

    // Table-driven vectors, with out_ready held high.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply_stimulus(v.sel, v.x, v.q, v.r);
      check_output(v.sel, v.lat);
      @(posedge clk);
      #1;
      chk("out_valid_clears", ov(v.sel), 0);
      chk("in_ready_returns", rdy(v.sel), 1);
    end

    // Backpressure: outputs must hold while out_ready stays low.
    out_ready_a = 1'b0;
    apply_stimulus(0, 32'd12345, 1, 4154);
    check_output(0, EE ? 3 : 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_out_q", out_q_a, 1);
      chk("bp_out_r", out_r_a, 4154);
      chk("bp_in_ready", in_ready_a, 0);
    end
    @(negedge clk);
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", out_valid_a, 0);
    chk("bp_release_in_ready", in_ready_a, 1);

    // Asynchronous reset mid-ITER: clear immediately, no stale result after release.
    apply_stimulus(0, 32'd12345, 1, 4154);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", in_ready_a, 0);
    chk("midreset_out_valid", out_valid_a, 0);
    chk("midreset_out_q", out_q_a, 0);
    chk("midreset_out_r", out_r_a, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_result", out_valid_a, 0);
    end
    apply_stimulus(0, 32'd16382, 2, 0);
    check_output(0, 4);
    @(posedge clk);
    #1;
    chk("post_reset_out_valid_clears", out_valid_a, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_mersenne_seq.md
Name: divider_mersenne_seq

Overview:
Parametrised sequential quotient/remainder unit for Mersenne divisors D = 2^K-1 on a W-bit unsigned dividend. It extends the fixed combinational divide-by-8191 block: W and K are parameters, one fold iteration runs per clock, and valid/ready handshakes sit on both sides. It feeds hash/modular-index logic that needs x mod (2^K-1) at full clock rate without a long combinational chain.

Parameters:
W, 32, dividend width in bits; W >= K.
K, 13, divisor exponent, D = 2^K-1; K >= 2.
ITERS (localparam), ceil(W/K), number of quotient estimates including q0. Default is 3.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  dividend valid
in_ready  out  1  block can accept a dividend (registered)
in_x  in  W  dividend, unsigned
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_q  out  W-K+1  quotient floor(x/D)
out_r  out  K  remainder x mod D, range 0..D-1

Behaviour:
- Reset (async, rst_n=0), applies even mid-operation:
  - state=IDLE; in_ready=0, out_valid=0, out_q=0, out_r=0; internal v1, q and iteration counter all cleared.
  - in_ready rises on the first clk edge after rst_n deasserts.
  - Any in-flight operation is discarded; no result is emitted for it.
- States:
  - IDLE: in_ready=1. On the edge with in_valid&in_ready:
    - register x; v1 = x+1 (W+1 bits, no overflow);
    - q = v1>>K;
    - cnt = ITERS-1; in_ready<=0.
    - Next state is ITER, or RESULT if ITERS==1.
  - ITER: each edge computes q <= (q + v1)>>K and decrements cnt. The sum uses W+2 bits internally. When cnt reaches 1 on that edge, next state is RESULT.
  - RESULT: one edge registers:
    - out_q <= q;
    - out_r <= (x + q) & D, computed mod 2^K;
    - out_valid <= 1; next state is DONE.
  - DONE: out_valid, out_q and out_r are held stable while out_ready=0. On the edge with out_valid&out_ready: out_valid<=0, in_ready<=1, next state IDLE.
- Timing:
  - Latency: out_valid rises exactly ITERS+1 edges after the accept edge. Default is 4.
  - in_ready is never 1 in the same cycle as out_valid, so there is no simultaneous accept/return.
  - Throughput is one result per ITERS+2 cycles minimum.
- Arithmetic: the quotient estimate is monotone non-decreasing and exact after ITERS estimates for every x in 0..2^W-1.
- Boundaries:
  - x=0 gives q=0, r=0.
  - x=D gives q=1, r=0; the remainder never equals D.
  - x=2^W-1 must not overflow v1 or the sum.
- in_x and in_valid are ignored outside IDLE. out_ready is ignored unless out_valid=1.

Optional Feature:
DIV_EARLY_EXIT_EN
- Defined: in ITER, if the next estimate equals the current q, the FSM skips the remaining iterations and goes to RESULT next edge. Output values are unchanged; latency becomes data-dependent, minimum 3 edges after accept.
- Undefined: fixed latency of ITERS+1 edges.
- The handshake protocol is identical either way.

Test Plan:
- Defaults, x=8191, out_ready=1 -> q=1, r=0; out_valid exactly 4 edges after accept (3 with DIV_EARLY_EXIT_EN).
- Defaults, x=8190 -> q=0, r=8190; x=0 -> q=0, r=0.
- Defaults, x=0xFFFFFFFF -> q=524352, r=63; no overflow.
- W=16, K=4 (ITERS=4), x=1000 -> q=66, r=10; x=15 -> q=1, r=0; latency 5 edges.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; accept completes in 1 cycle, then in_ready=1 next cycle.
- Reset mid-ITER: drop rst_n asynchronously -> all outputs 0 immediately, no stale result after release. The next input, x=16382, yields q=2, r=0.
